wired_cdb_sched: RTL and testbench

- Schedules result writeback from N execution-side producers (ALU ×2, LSU, MUL, DIV issue queues) onto the 2-lane common data bus.
- Lane is fixed by the ROB-id LSB (lane k carries only wid[0]==k), matching how consumers index the CDB.
- Per-lane round-robin arbitration with a registered CDB output stage.
- Flush-aware. Sits between the issue-queue CDB outputs and every CDB consumer (ROB, IQ wakeup, dispatch forwarding).

---
 rtl/wired_cdb_sched.sv | 166 ++++++++++++++++
 tb/tb_wired_cdb_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_cdb_sched.sv
// Two-lane CDB writeback scheduler: per-lane round-robin over producers, lane chosen by ROB-id bit 0.
// Optional per-lane perf counters when WIRED_CDB_SCHED_PERF_EN is defined.
module wired_cdb_sched #(
    parameter int PORT_CNT = 5,
    parameter int ROB_LEN  = 6,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [PORT_CNT-1:0]          req_valid_i,
    input  logic [PORT_CNT*ROB_LEN-1:0]  req_wid_i,
    input  logic [PORT_CNT*DATA_W-1:0]   req_wdata_i,
    output logic [PORT_CNT-1:0]          req_ready_o,
    output logic [1:0]                   cdb_valid_o,
    output logic [2*ROB_LEN-1:0]         cdb_wid_o,
`ifdef WIRED_CDB_SCHED_PERF_EN
    output logic [2*DATA_W-1:0]          cdb_wdata_o,
    output logic [63:0]                  perf_conflict_o,
    output logic [63:0]                  perf_busy_o
`else
    output logic [2*DATA_W-1:0]          cdb_wdata_o
`endif
);

    localparam int PTR_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

    logic [1:0][PTR_W-1:0]    r_ptr;
    logic [1:0]               r_cdb_valid;
    logic [1:0][ROB_LEN-1:0]  r_cdb_wid;
    logic [1:0][DATA_W-1:0]   r_cdb_wdata;

    logic [1:0][PORT_CNT-1:0] w_cand;
    logic [1:0]               w_found;
    logic [1:0]               w_grant;
    logic [1:0]               w_multi;
    logic [1:0][PTR_W-1:0]    w_win;
    logic [1:0][PTR_W-1:0]    w_ptr_nxt;
    logic [1:0][ROB_LEN-1:0]  w_sel_wid;
    logic [1:0][DATA_W-1:0]   w_sel_wdata;

    // Split valid requests into per-lane candidate sets using the ROB-id LSB.
    always_comb begin
        w_cand = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            if (req_wid_i[p*ROB_LEN]) begin
                w_cand[1][p] = req_valid_i[p];
            end else begin
                w_cand[0][p] = req_valid_i[p];
            end
        end
    end

    // Per-lane round-robin: first candidate at or above the lane pointer, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 2'b00;
        w_win   = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < PORT_CNT; i++) begin
                idx = int'(r_ptr[k]) + i;
                if (idx >= PORT_CNT) begin
                    idx = idx - PORT_CNT;
                end else begin
                    idx = idx;
                end
                if (!w_found[k] && w_cand[k][idx]) begin
                    w_found[k] = 1'b1;
                    w_win[k]   = PTR_W'(idx);
                end else begin
                    w_found[k] = w_found[k];
                end
            end
        end
    end

    // Grant qualification, winner data selection and next-pointer computation.
    always_comb begin
        w_grant     = 2'b00;
        w_multi     = 2'b00;
        w_ptr_nxt   = r_ptr;
        w_sel_wid   = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            w_grant[k]     = w_found[k] && !flush_i;
            w_multi[k]     = (w_cand[k] & (w_cand[k] - PORT_CNT'(1))) != '0;
            w_sel_wid[k]   = req_wid_i[int'(w_win[k])*ROB_LEN +: ROB_LEN];
            w_sel_wdata[k] = req_wdata_i[int'(w_win[k])*DATA_W +: DATA_W];
            if (w_win[k] == PTR_W'(PORT_CNT - 1)) begin
                w_ptr_nxt[k] = '0;
            end else begin
                w_ptr_nxt[k] = w_win[k] + PTR_W'(1);
            end
        end
    end

    // Ready goes only to the winner of the port's own lane; suppressed during reset.
    always_comb begin
        req_ready_o = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            if (req_wid_i[p*ROB_LEN]) begin
                req_ready_o[p] = !rst && w_grant[1] && (w_win[1] == PTR_W'(p));
            end else begin
                req_ready_o[p] = !rst && w_grant[0] && (w_win[0] == PTR_W'(p));
            end
        end
    end

    // Pointer advance and registered CDB stage; id/data hold when the lane is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= 2'b00;
            r_cdb_wid   <= '0;
            r_cdb_wdata <= '0;
        end else begin
            r_cdb_valid <= w_grant;
            for (int k = 0; k < 2; k++) begin
                if (w_grant[k]) begin
                    r_ptr[k]       <= w_ptr_nxt[k];
                    r_cdb_wid[k]   <= w_sel_wid[k];
                    r_cdb_wdata[k] <= w_sel_wdata[k];
                end else begin
                    r_ptr[k]       <= r_ptr[k];
                    r_cdb_wid[k]   <= r_cdb_wid[k];
                    r_cdb_wdata[k] <= r_cdb_wdata[k];
                end
            end
        end
    end

    assign cdb_valid_o = r_cdb_valid;
    assign cdb_wid_o   = r_cdb_wid;
    assign cdb_wdata_o = r_cdb_wdata;

`ifdef WIRED_CDB_SCHED_PERF_EN
    logic [1:0][31:0] r_perf_conflict;
    logic [1:0][31:0] r_perf_busy;

    // Saturating per-lane counters for contended cycles and granted cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_conflict <= '0;
            r_perf_busy     <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_multi[k] && !flush_i && (r_perf_conflict[k] != 32'hFFFF_FFFF)) begin
                    r_perf_conflict[k] <= r_perf_conflict[k] + 32'd1;
                end else begin
                    r_perf_conflict[k] <= r_perf_conflict[k];
                end
                if (w_grant[k] && (r_perf_busy[k] != 32'hFFFF_FFFF)) begin
                    r_perf_busy[k] <= r_perf_busy[k] + 32'd1;
                end else begin
                    r_perf_busy[k] <= r_perf_busy[k];
                end
            end
        end
    end

    assign perf_conflict_o = r_perf_conflict;
    assign perf_busy_o     = r_perf_busy;
`endif

endmodule

// File: tb/tb_wired_cdb_sched.sv
// Scoreboard bench for wired_cdb_sched: directed scenarios plus randomized producer traffic.
module tb_wired_cdb_sched;
    localparam int N  = 5;
    localparam int RL = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [N-1:0]      vld = '0;
    logic [N*RL-1:0]   wid_f;
    logic [N*DW-1:0]   dat_f;
    logic [N-1:0]      ready;
    logic [1:0]        cdb_valid;
    logic [2*RL-1:0]   cdb_wid;
    logic [2*DW-1:0]   cdb_wdata;

    logic [RL-1:0]     pw[N];
    logic [DW-1:0]     pd[N];

    typedef struct {
        logic [RL-1:0] w;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int   mptr[2];
    int   total = 0;
    int   bad = 0;

    wired_cdb_sched #(.PORT_CNT(N), .ROB_LEN(RL), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(vld), .req_wid_i(wid_f), .req_wdata_i(dat_f),
        .req_ready_o(ready), .cdb_valid_o(cdb_valid),
        .cdb_wid_o(cdb_wid), .cdb_wdata_o(cdb_wdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            wid_f[p*RL +: RL] = pw[p];
            dat_f[p*DW +: DW] = pd[p];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: reference model predicts grants at the negedge, pushes expected CDB
    // entries, then returns 1 time unit after the next rising edge.
    task automatic tick(output logic [N-1:0] g);
        logic [N-1:0] er;
        int best, bd, d;
        ent_t e;
        @(negedge clk);
        er = '0;
        for (int k = 0; k < 2; k++) begin
            best = -1;
            bd = N;
            for (int p = 0; p < N; p++) begin
                if (vld[p] && int'(pw[p][0]) == k) begin
                    d = (p - mptr[k] + N) % N;
                    if (d < bd) begin
                        bd = d;
                        best = p;
                    end
                end
            end
            if (best >= 0 && !flush) begin
                er[best] = 1'b1;
                mptr[k] = (best + 1) % N;
                e.w = pw[best];
                e.d = pd[best];
                if (k == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        chk("req_ready", 64'(ready), 64'(er));
        g = er;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges; model state cleared alongside.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        mptr[0] = 0;
        mptr[1] = 0;
        #1;
        chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic mon_lane(input int k);
        ent_t e;
        logic v;
        v = cdb_valid[k];
        if (k == 0) begin
            if (v) begin
                if (q0.size() == 0) begin
                    chk("lane0_unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = q0.pop_front();
                    chk("lane0_wid", 64'(cdb_wid[RL-1:0]), 64'(e.w));
                    chk("lane0_wdata", 64'(cdb_wdata[DW-1:0]), 64'(e.d));
                end
            end else if (q0.size() != 0) begin
                void'(q0.pop_front());
                chk("lane0_missing_valid", 64'(0), 64'(1));
            end
        end else begin
            if (v) begin
                if (q1.size() == 0) begin
                    chk("lane1_unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = q1.pop_front();
                    chk("lane1_wid", 64'(cdb_wid[2*RL-1:RL]), 64'(e.w));
                    chk("lane1_wdata", 64'(cdb_wdata[2*DW-1:DW]), 64'(e.d));
                end
            end else if (q1.size() != 0) begin
                void'(q1.pop_front());
                chk("lane1_missing_valid", 64'(0), 64'(1));
            end
        end
    endtask

    // Monitor: sample the registered CDB shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                mon_lane(0);
                mon_lane(1);
            end
        end
    end

    initial begin
        logic [N-1:0] g;
        int rr[5];
        rr = '{0, 2, 4, 0, 2};
        for (int p = 0; p < N; p++) begin
            pw[p] = RL'(p);
            pd[p] = DW'(p * 256 + 1);
        end
        do_reset();

        // Reset mid-traffic: all ports valid.
        vld = 5'b11111;
        tick(g);
        tick(g);
        do_reset();
        tick(g);
        chk("rst_first_grant", 64'(g), 64'(5'b00011));

        // Lane steering.
        vld = 5'b01010;
        pw[1] = 6'h0A; pd[1] = 32'h1111;
        pw[3] = 6'h05; pd[3] = 32'h3333;
        tick(g);
        chk("steer_ready", 64'(g), 64'(5'b01010));
        chk("steer_valid", 64'(cdb_valid), 64'(2'b11));
        chk("steer_wid", 64'(cdb_wid), 64'({6'h05, 6'h0A}));
        chk("steer_wdata", 64'(cdb_wdata), {32'h3333, 32'h1111});

        // Round-robin over ports 0,2,4 on lane 0.
        vld = '0;
        do_reset();
        vld = 5'b10101;
        for (int p = 0; p < N; p++) begin
            pw[p] = RL'(2 * p);
            pd[p] = DW'(32'hA000 + p);
        end
        for (int i = 0; i < 5; i++) begin
            tick(g);
            chk("rr_grant", 64'(g), 64'(1) << rr[i]);
        end

        // Flush blocks the grant; released flush grants next cycle.
        vld = 5'b00001;
        pw[0] = 6'h02; pd[0] = 32'h0202;
        flush = 1'b1;
        tick(g);
        chk("flush_ready", 64'(g), 64'(0));
        chk("flush_cdb_valid0", 64'(cdb_valid[0]), 64'(0));
        flush = 1'b0;
        tick(g);
        chk("unflush_ready", 64'(g), 64'(1));
        chk("unflush_cdb_valid0", 64'(cdb_valid[0]), 64'(1));

        // Hold-and-retry: port4 loses to port0 then wins with unchanged payload.
        vld = '0;
        do_reset();
        vld = 5'b10001;
        pw[0] = 6'h04; pd[0] = 32'hAAAA;
        pw[4] = 6'h08; pd[4] = 32'h4444;
        tick(g);
        chk("retry_first", 64'(g), 64'(5'b00001));
        chk("retry_wid0", 64'(cdb_wid[RL-1:0]), 64'(6'h04));
        vld[0] = 1'b0;
        tick(g);
        chk("retry_second", 64'(g), 64'(5'b10000));
        chk("retry_wid4", 64'(cdb_wid[RL-1:0]), 64'(6'h08));
        chk("retry_wdata4", 64'(cdb_wdata[DW-1:0]), 64'(32'h4444));

        // Randomized producers that hold until ready, with flush and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            tick(g);
            for (int p = 0; p < N; p++) begin
                if (g[p] || !vld[p]) begin
                    vld[p] = ($urandom_range(0, 99) < 60);
                    pw[p]  = RL'($urandom);
                    pd[p]  = $urandom;
                end else if (flush && $urandom_range(0, 99) < 30) begin
                    vld[p] = 1'b0;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end

        vld = '0;
        flush = 1'b0;
        tick(g);
        tick(g);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
